// File: rtl/pcode_rx_pkg.sv
// pcode_rx_pkg: shared acquisition state encoding and default correlator constants
package pcode_rx_pkg;
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;
  localparam int INT_LEN_DEF   = 1023;
  localparam int CNT_WIDTH_DEF = 11;
  localparam int THRESH_DEF    = 900;
endpackage

// File: rtl/pcode_corr_acc.sv
// pcode_corr_acc: integrate-and-dump chip correlator with registered dump outputs
//   in : clk, reset_n (async, active low), clear (sync restart), en (chip strobe), match (rx==ref)
//   out: dump, hit_now (combinational decision on the last-chip edge)
//        corr, dump_valid, hit (registered dump results)
module pcode_corr_acc
  import pcode_rx_pkg::*;
#(
  parameter int INT_LEN   = INT_LEN_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int THRESH    = THRESH_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        en,
  input  logic                        match,
  output logic                        dump,
  output logic                        hit_now,
  output logic signed [CNT_WIDTH:0]   corr,
  output logic                        dump_valid,
  output logic                        hit
);
  logic signed [CNT_WIDTH:0] acc, acc_next;
  logic        [CNT_WIDTH:0] mag;
  logic        [CNT_WIDTH-1:0] chip_cnt;
  always_comb begin
    acc_next = match ? acc + (CNT_WIDTH+1)'(1) : acc - (CNT_WIDTH+1)'(1);
    // magnitude: an inverted data bit gives a strong negative sum that still counts as a hit
    mag      = acc_next[CNT_WIDTH] ? -acc_next : acc_next;
    hit_now  = mag >= (CNT_WIDTH+1)'(THRESH);
    dump     = en && chip_cnt == CNT_WIDTH'(INT_LEN - 1);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc        <= '0;
      chip_cnt   <= '0;
      corr       <= '0;
      dump_valid <= 1'b0;
      hit        <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      chip_cnt   <= '0;
      corr       <= '0;
      dump_valid <= 1'b0;
      hit        <= 1'b0;
    end else begin
      dump_valid <= dump;
      if (en) begin
        acc      <= dump ? '0 : acc_next;
        chip_cnt <= dump ? '0 : chip_cnt + 1'b1;
      end
      if (dump) begin
        corr <= acc_next;
        hit  <= hit_now;
      end
    end
endmodule

// File: rtl/pcode_correlator.sv
// pcode_correlator: P-code despreader with SEARCH/VERIFY/LOCK acquisition and slip requests
//   in : clk, reset_n (async, active low), clear (sync restart, beats en), en (chip strobe),
//        rx_chip (received chip), ref_chip (aligned replica chip)
//   out: corr (signed dump), dump_valid (pulse), hit (held per dump), slip_req (pulse),
//        locked (state==LOCK), state (SEARCH=0, VERIFY=1, LOCK=2)
module pcode_correlator
  import pcode_rx_pkg::*;
#(
  parameter int INT_LEN   = INT_LEN_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int THRESH    = THRESH_DEF,
  parameter int LOCK_CNT  = 3,
  parameter int LOSS_CNT  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      en,
  input  logic                      rx_chip,
  input  logic                      ref_chip,
  output logic signed [CNT_WIDTH:0] corr,
  output logic                      dump_valid,
  output logic                      hit,
  output logic                      slip_req,
  output logic                      locked,
  output logic [1:0]                state
);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  state_t st, st_n;
  logic [HW-1:0] hit_cnt, hit_cnt_n;
  logic [MW-1:0] miss_cnt, miss_cnt_n;
  logic dump, hit_now, slip_n;
  pcode_corr_acc #(
    .INT_LEN  (INT_LEN),
    .CNT_WIDTH(CNT_WIDTH),
    .THRESH   (THRESH)
  ) u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .en        (en),
    .match     (rx_chip ~^ ref_chip),
    .dump      (dump),
    .hit_now   (hit_now),
    .corr      (corr),
    .dump_valid(dump_valid),
    .hit       (hit)
  );
  assign state = st;
  // the FSM only moves on dump edges, using the fresh hit decision of that dump
  always_comb begin
    st_n       = st;
    hit_cnt_n  = hit_cnt;
    miss_cnt_n = miss_cnt;
    slip_n     = 1'b0;
    if (dump)
      case (st)
        SEARCH:
          if (hit_now) begin
            hit_cnt_n  = HW'(1);
            miss_cnt_n = '0;
            st_n       = LOCK_CNT == 1 ? LOCK : VERIFY;
          end else slip_n = 1'b1;
        VERIFY:
          if (hit_now) begin
            hit_cnt_n = hit_cnt + HW'(1);
            if (hit_cnt + HW'(1) == HW'(LOCK_CNT)) begin
              st_n       = LOCK;
              miss_cnt_n = '0;
            end
          end else begin
            st_n      = SEARCH;
            slip_n    = 1'b1;
            hit_cnt_n = '0;
          end
        LOCK:
          if (hit_now) miss_cnt_n = '0;
          else if (miss_cnt + MW'(1) == MW'(LOSS_CNT)) begin
            st_n       = SEARCH;
            slip_n     = 1'b1;
            hit_cnt_n  = '0;
            miss_cnt_n = '0;
          end else miss_cnt_n = miss_cnt + MW'(1);
        default: begin
          st_n       = SEARCH;
          hit_cnt_n  = '0;
          miss_cnt_n = '0;
        end
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st       <= SEARCH;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      slip_req <= 1'b0;
      locked   <= 1'b0;
    end else if (clear) begin
      st       <= SEARCH;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      slip_req <= 1'b0;
      locked   <= 1'b0;
    end else begin
      st       <= st_n;
      hit_cnt  <= hit_cnt_n;
      miss_cnt <= miss_cnt_n;
      slip_req <= slip_n;
      locked   <= st_n == LOCK;
    end
endmodule

// File: tb/tb_pcode_correlator.sv
// tb_pcode_correlator: randomized self-checking bench against a dump-level reference model
module tb_pcode_correlator;
  localparam int IL = 16, CW = 5, TH = 14, LC = 3, LS = 2;
  localparam int W = CW + 7;
  logic clk = 1'b0, reset_n = 1'b0, clear = 1'b0, en = 1'b0, rx_chip = 1'b0, ref_chip = 1'b0;
  logic signed [CW:0] corr;
  logic dump_valid, hit, slip_req, locked;
  logic [1:0] state;
  int checks = 0, errors = 0, spur = 0;
  int m_state = 0, m_hits = 0, m_miss = 0;
  logic signed [CW:0] e_corr = '0;
  logic e_hit = 1'b0, e_slip = 1'b0, e_locked = 1'b0;

  always #5 clk = ~clk;

  pcode_correlator #(
    .INT_LEN(IL), .CNT_WIDTH(CW), .THRESH(TH), .LOCK_CNT(LC), .LOSS_CNT(LS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .rx_chip(rx_chip),
    .ref_chip(ref_chip), .corr(corr), .dump_valid(dump_valid), .hit(hit),
    .slip_req(slip_req), .locked(locked), .state(state)
  );

  function automatic logic [W-1:0] obs();
    return {dump_valid, corr, hit, slip_req, locked, state};
  endfunction

  function automatic logic [W-1:0] want(input logic dv);
    return {dv, e_corr, e_hit, e_slip, e_locked, 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_hits = 0; m_miss = 0;
    e_corr = '0; e_hit = 1'b0; e_slip = 1'b0; e_locked = 1'b0;
  endtask

  // a dump of nm agreements out of IL chips: corr = nm - (IL - nm)
  task automatic model_dump(input int nm);
    int c;
    c = 2 * nm - IL;
    e_corr = (CW+1)'(c);
    e_hit = (c >= TH) || (-c >= TH);
    e_slip = 1'b0;
    if (m_state == 0) begin
      if (e_hit) begin m_hits = 1; m_state = (LC == 1) ? 2 : 1; end
      else e_slip = 1'b1;
    end else if (m_state == 1) begin
      if (e_hit) begin
        m_hits++;
        if (m_hits == LC) begin m_state = 2; m_miss = 0; end
      end else begin m_state = 0; e_slip = 1'b1; m_hits = 0; end
    end else begin
      if (e_hit) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == LS) begin m_state = 0; e_slip = 1'b1; m_hits = 0; m_miss = 0; end
      end
    end
    e_locked = (m_state == 2);
  endtask

  // drive one full integration with nm agreements in random positions and gap idle cycles between chips
  task automatic run_dump(input int nm, input int gap);
    logic [IL-1:0] mk;
    int j;
    logic t;
    mk = '0;
    for (int i = 0; i < nm; i++) mk[i] = 1'b1;
    for (int i = IL - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = mk[i]; mk[i] = mk[j]; mk[j] = t;
    end
    spur = 0;
    for (int i = 0; i < IL; i++) begin
      @(negedge clk);
      spur += int'(dump_valid);
      en = 1'b1;
      ref_chip = 1'($urandom);
      rx_chip = mk[i] ? ref_chip : ~ref_chip;
      if (i < IL - 1)
        repeat (gap) begin
          @(negedge clk);
          spur += int'(dump_valid);
          en = 1'b0;
        end
    end
    @(negedge clk);
    en = 1'b0;
    model_dump(nm);
  endtask

  task automatic partial(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b1;
      ref_chip = 1'($urandom);
      rx_chip = 1'($urandom);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    en = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== want(1'b0)) begin
      errors++;
      $display("FAIL reset: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b0));
    end
    reset_n = 1'b1;
  endtask

  task automatic test_match_dump();
    run_dump(IL, 0);
    checks++;
    if (obs() !== want(1'b1)) begin
      errors++;
      $display("FAIL match_dump: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b1));
    end
    @(negedge clk);
    checks++;
    if (dump_valid !== 1'b0) begin
      errors++;
      $display("FAIL match_dump_pulse: dump_valid got %b want 0", dump_valid);
    end
  endtask

  task automatic test_lock_gaps();
    do_clear();
    for (int k = 0; k < 3; k++) begin
      run_dump(IL, 3);
      checks++;
      if (obs() !== want(1'b1)) begin
        errors++;
        $display("FAIL lock_gaps dump%0d: {dv,corr,hit,slip,lock,st} got %b want %b", k, obs(), want(1'b1));
      end
      checks++;
      if (spur !== 0) begin
        errors++;
        $display("FAIL lock_gaps spurious dump%0d: extra dumps got %0d want 0", k, spur);
      end
    end
  endtask

  task automatic test_loss();
    for (int k = 0; k < 2; k++) begin
      run_dump(IL - 2, 0);
      checks++;
      if (obs() !== want(1'b1)) begin
        errors++;
        $display("FAIL loss dump%0d: {dv,corr,hit,slip,lock,st} got %b want %b", k, obs(), want(1'b1));
      end
    end
    @(negedge clk);
    checks++;
    if ({dump_valid, slip_req} !== 2'b00) begin
      errors++;
      $display("FAIL loss_pulse: {dv,slip} got %b want 00", {dump_valid, slip_req});
    end
  endtask

  task automatic test_inverted();
    do_clear();
    run_dump(0, 0);
    checks++;
    if (obs() !== want(1'b1)) begin
      errors++;
      $display("FAIL inverted: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b1));
    end
  endtask

  task automatic test_half();
    do_clear();
    run_dump(IL / 2, 1);
    checks++;
    if (obs() !== want(1'b1)) begin
      errors++;
      $display("FAIL half: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b1));
    end
    @(negedge clk);
    checks++;
    if ({dump_valid, slip_req} !== 2'b00) begin
      errors++;
      $display("FAIL half_slip_pulse: {dv,slip} got %b want 00", {dump_valid, slip_req});
    end
  endtask

  task automatic test_single_miss();
    int seq[6] = '{IL, IL, IL, IL - 2, IL, IL - 2};
    do_clear();
    foreach (seq[k]) begin
      run_dump(seq[k], 0);
      checks++;
      if (obs() !== want(1'b1)) begin
        errors++;
        $display("FAIL single_miss dump%0d: {dv,corr,hit,slip,lock,st} got %b want %b", k, obs(), want(1'b1));
      end
    end
  endtask

  task automatic test_clear();
    do_clear();
    partial(5);
    do_clear();
    run_dump(IL, 0);
    checks++;
    if (spur !== 0) begin
      errors++;
      $display("FAIL clear_restart: early dumps got %0d want 0", spur);
    end
    checks++;
    if (obs() !== want(1'b1)) begin
      errors++;
      $display("FAIL clear_restart dump: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b1));
    end
    partial(IL - 1);
    @(negedge clk);
    clear = 1'b1;
    en = 1'b1;
    rx_chip = ref_chip;
    @(negedge clk);
    clear = 1'b0;
    en = 1'b0;
    model_reset();
    checks++;
    if (obs() !== want(1'b0)) begin
      errors++;
      $display("FAIL clear_last_chip: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b0));
    end
    run_dump(IL - 1, 0);
    checks++;
    if (obs() !== want(1'b1) || spur !== 0) begin
      errors++;
      $display("FAIL clear_last_chip next: {dv,corr,hit,slip,lock,st} got %b want %b early %0d", obs(), want(1'b1), spur);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    run_dump(IL, 0);
    checks++;
    if (obs() !== want(1'b1)) begin
      errors++;
      $display("FAIL async_pre: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b1));
    end
    partial(7);
    @(negedge clk);
    en = 1'b0;
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== want(1'b0)) begin
      errors++;
      $display("FAIL async_reset: {dv,corr,hit,slip,lock,st} got %b want %b", obs(), want(1'b0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_dump(IL, 0);
    checks++;
    if (obs() !== want(1'b1) || spur !== 0) begin
      errors++;
      $display("FAIL async_after: {dv,corr,hit,slip,lock,st} got %b want %b early %0d", obs(), want(1'b1), spur);
    end
  endtask

  task automatic test_random();
    int nm, sel;
    do_clear();
    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(5, 0);
      nm = (sel == 0) ? IL : (sel == 1) ? 0 : (sel == 2) ? IL - 1 : (sel == 3) ? 1 :
           (sel == 4) ? IL - 2 : $urandom_range(IL, 0);
      run_dump(nm, $urandom_range(2, 0));
      checks++;
      if (obs() !== want(1'b1) || spur !== 0) begin
        errors++;
        $display("FAIL random dump%0d nm=%0d: {dv,corr,hit,slip,lock,st} got %b want %b early %0d",
                 k, nm, obs(), want(1'b1), spur);
      end
    end
  endtask

  initial begin
    test_reset();
    test_match_dump();
    test_lock_gaps();
    test_loss();
    test_inverted();
    test_half();
    test_single_miss();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
